// File: rtl/bomb_pkg.sv
// Shared types and helpers for the BombMan bomb engine: widths, game state
// encoding and the grid cell index mapping.
package bomb_pkg;

  localparam int COORD_W = 4;  // default coordinate width
  localparam int PIW     = 2;  // player index width (up to 4 players)
  localparam int FW      = 4;  // fuse counter width (FUSE_TICKS <= 15)
  localparam int BCW     = 3;  // per-player live bomb count width (<= 7)

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_WIN  = 2'd1,
    ST_DRAW = 2'd2
  } game_st_e;

  function automatic int hw_of(input int max_health);
    return $clog2(max_health + 1);
  endfunction

  function automatic int idx(input int x, input int y, input int grid_w);
    return y * grid_w + x;
  endfunction

endpackage

// File: rtl/bomb_cell.sv
// One grid cell of bomb state: fuse counter and owner. A load always lands on
// an empty cell, so it never competes with the tick update.
module bomb_cell
  import bomb_pkg::*;
#(
  parameter int FUSE_TICKS = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           load,
  input  logic [PIW-1:0] load_owner,
  input  logic           in_blast,
  output logic           live,
  output logic           det,
  output logic [PIW-1:0] owner
);

  logic [FW-1:0]  fuse_q, fuse_d;
  logic [PIW-1:0] owner_q, owner_d;

  always_comb begin
    fuse_d  = fuse_q;
    owner_d = owner_q;
    if (load) begin
      fuse_d  = FW'(FUSE_TICKS);
      owner_d = load_owner;
    end else if (tick && fuse_q != '0) begin
      if (fuse_q == FW'(1)) begin
        fuse_d = '0;
      end else if (in_blast) begin
        // chained: caught by a neighbouring blast, goes off on the next tick
        fuse_d = FW'(1);
      end else begin
        fuse_d = fuse_q - FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fuse_q <= '0;
    end else begin
      fuse_q <= fuse_d;
    end
  end

  // owner is only meaningful while the fuse is running
  always_ff @(posedge clk) begin
    owner_q <= owner_d;
  end

  assign live  = (fuse_q != '0);
  assign det   = (fuse_q == FW'(1));
  assign owner = owner_q;

endmodule

// File: rtl/bomb_engine.sv
// Bomb timer / explosion engine: placement arbitration, per-cell fuses, blast
// cross network with chain reaction, damage and end-of-game decision.
module bomb_engine
  import bomb_pkg::*;
#(
  parameter int GRID_W      = 10,
  parameter int GRID_H      = 10,
  parameter int CW          = COORD_W,
  parameter int NUM_PLAYERS = 2,
  parameter int FUSE_TICKS  = 3,
  parameter int BLAST_R     = 2,
  parameter int MAX_HEALTH  = 3,
  parameter int MAX_BOMBS   = 1
) (
  input  logic                                     bombClk,
  input  logic                                     rst,
  input  logic                                     tick_en,
  input  logic [NUM_PLAYERS-1:0]                   place_v,
  input  logic [NUM_PLAYERS*CW-1:0]                place_x,
  input  logic [NUM_PLAYERS*CW-1:0]                place_y,
  output logic [NUM_PLAYERS-1:0]                   place_rdy,
  input  logic [NUM_PLAYERS*CW-1:0]                player_x,
  input  logic [NUM_PLAYERS*CW-1:0]                player_y,
  output logic [GRID_W*GRID_H-1:0]                 bomb_map,
  output logic [GRID_W*GRID_H-1:0]                 blast_map,
  output logic [NUM_PLAYERS*hw_of(MAX_HEALTH)-1:0] health,
  output logic [NUM_PLAYERS-1:0]                   alive,
  output logic                                     game_over,
  output logic [1:0]                               winner,
  output logic                                     draw
);

  localparam int NCELL = GRID_W * GRID_H;
  localparam int HW    = hw_of(MAX_HEALTH);
  localparam int IDXW  = $clog2(NCELL);

  logic [CW-1:0]   req_x [NUM_PLAYERS];
  logic [CW-1:0]   req_y [NUM_PLAYERS];
  logic [CW-1:0]   pos_x [NUM_PLAYERS];
  logic [CW-1:0]   pos_y [NUM_PLAYERS];
  logic [IDXW-1:0] req_idx [NUM_PLAYERS];
  logic [IDXW-1:0] pos_idx [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] req_in_rng, pos_in_rng, hit;

  logic [NCELL-1:0] cell_live, cell_det, cell_load, blast;
  logic [PIW-1:0]   cell_owner [NCELL];
  logic [PIW-1:0]   load_owner [NCELL];

  logic [BCW-1:0] count_q  [NUM_PLAYERS];
  logic [BCW-1:0] count_d  [NUM_PLAYERS];
  logic [HW-1:0]  health_q [NUM_PLAYERS];
  logic [HW-1:0]  health_d [NUM_PLAYERS];
  logic [NCELL-1:0] blast_q, blast_d;
  game_st_e       state_q, state_d;
  logic [PIW-1:0] winner_q, winner_d;

  logic           playing;
  logic           clash;
  int             dec;
  int             n_alive;
  logic [PIW-1:0] last_alive;

  assign playing = (state_q == ST_PLAY);

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      req_x[p]      = place_x[p*CW +: CW];
      req_y[p]      = place_y[p*CW +: CW];
      pos_x[p]      = player_x[p*CW +: CW];
      pos_y[p]      = player_y[p*CW +: CW];
      req_in_rng[p] = (int'(req_x[p]) < GRID_W) && (int'(req_y[p]) < GRID_H);
      pos_in_rng[p] = (int'(pos_x[p]) < GRID_W) && (int'(pos_y[p]) < GRID_H);
      req_idx[p]    = IDXW'(idx(int'(req_x[p]), int'(req_y[p]), GRID_W));
      pos_idx[p]    = IDXW'(idx(int'(pos_x[p]), int'(pos_y[p]), GRID_W));
    end
  end

  // Placement: lower player index wins a contested cell, even if it is refused
  always_comb begin
    place_rdy = '0;
    cell_load = '0;
    clash     = 1'b0;
    for (int c = 0; c < NCELL; c++) begin
      load_owner[c] = '0;
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      clash = 1'b0;
      for (int q = 0; q < p; q++) begin
        if (place_v[q] && req_x[q] == req_x[p] && req_y[q] == req_y[p]) begin
          clash = 1'b1;
        end
      end
      if (place_v[p] && req_in_rng[p] && !clash && playing &&
          health_q[p] != '0 && count_q[p] < BCW'(MAX_BOMBS) &&
          !cell_live[req_idx[p]]) begin
        place_rdy[p]           = 1'b1;
        cell_load[req_idx[p]]  = 1'b1;
        load_owner[req_idx[p]] = PIW'(p);
      end
    end
  end

  for (genvar c = 0; c < NCELL; c++) begin : g_cell
    bomb_cell #(
      .FUSE_TICKS(FUSE_TICKS)
    ) u_cell (
      .clk       (bombClk),
      .rst       (rst),
      .tick      (tick_en),
      .load      (cell_load[c]),
      .load_owner(load_owner[c]),
      .in_blast  (blast[c]),
      .live      (cell_live[c]),
      .det       (cell_det[c]),
      .owner     (cell_owner[c])
    );
  end

  // Blast cross of every detonating cell, clipped at the grid edges
  always_comb begin
    blast = '0;
    for (int y = 0; y < GRID_H; y++) begin
      for (int x = 0; x < GRID_W; x++) begin
        if (cell_det[idx(x, y, GRID_W)]) begin
          for (int k = -BLAST_R; k <= BLAST_R; k++) begin
            if (x + k >= 0 && x + k < GRID_W) blast[idx(x + k, y, GRID_W)] = 1'b1;
            if (y + k >= 0 && y + k < GRID_H) blast[idx(x, y + k, GRID_W)] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      hit[p] = pos_in_rng[p] && blast[pos_idx[p]];
    end
    blast_d = tick_en ? blast : blast_q;
  end

  // Bomb counts, damage and survivor tally on post-damage health
  always_comb begin
    dec        = 0;
    n_alive    = 0;
    last_alive = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      dec = 0;
      for (int c = 0; c < NCELL; c++) begin
        if (tick_en && cell_det[c] && int'(cell_owner[c]) == p) dec = dec + 1;
      end
      count_d[p]  = count_q[p] + BCW'(place_rdy[p]) - BCW'(dec);
      health_d[p] = health_q[p];
      if (tick_en && playing && hit[p] && health_q[p] != '0) begin
        health_d[p] = health_q[p] - HW'(1);
      end
      if (health_d[p] != '0) begin
        n_alive    = n_alive + 1;
        last_alive = PIW'(p);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    if (playing && tick_en) begin
      if (n_alive == 0) begin
        state_d = ST_DRAW;
      end else if (n_alive == 1) begin
        state_d  = ST_WIN;
        winner_d = last_alive;
      end
    end
  end

  always_ff @(posedge bombClk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_PLAY;
      winner_q <= '0;
      blast_q  <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        count_q[p]  <= '0;
        health_q[p] <= HW'(MAX_HEALTH);
      end
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      blast_q  <= blast_d;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        count_q[p]  <= count_d[p];
        health_q[p] <= health_d[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      health[p*HW +: HW] = health_q[p];
      alive[p]           = (health_q[p] != '0);
    end
  end

  assign bomb_map  = cell_live;
  assign blast_map = blast_q;
  assign game_over = (state_q != ST_PLAY);
  assign draw      = (state_q == ST_DRAW);
  assign winner    = winner_q;

endmodule

// File: tb/tb_bomb_engine.sv
// Testbench for bomb_engine: directed scenarios plus randomized traffic
// against a bomb-list reference model.
module tb_bomb_engine;

  localparam int GW = 10, GH = 10, NP = 2, CWB = 4, FUSE = 3, R = 2;
  localparam int MH = 3, MB = 1, HWB = 2, NC = GW * GH;

  logic              bombClk = 1'b0;
  logic              rst = 1'b0;
  logic              tick_en = 1'b0;
  logic [NP-1:0]     place_v = '0;
  logic [NP*CWB-1:0] place_x = '0, place_y = '0, player_x = '0, player_y = '0;
  logic [NP-1:0]     place_rdy;
  logic [NC-1:0]     bomb_map, blast_map;
  logic [NP*HWB-1:0] health;
  logic [NP-1:0]     alive;
  logic              game_over;
  logic [1:0]        winner;
  logic              draw;

  always #5 bombClk = ~bombClk;

  bomb_engine #(
    .GRID_W(GW), .GRID_H(GH), .CW(CWB), .NUM_PLAYERS(NP), .FUSE_TICKS(FUSE),
    .BLAST_R(R), .MAX_HEALTH(MH), .MAX_BOMBS(MB)
  ) dut (
    .bombClk(bombClk), .rst(rst), .tick_en(tick_en), .place_v(place_v),
    .place_x(place_x), .place_y(place_y), .place_rdy(place_rdy),
    .player_x(player_x), .player_y(player_y), .bomb_map(bomb_map),
    .blast_map(blast_map), .health(health), .alive(alive),
    .game_over(game_over), .winner(winner), .draw(draw)
  );

  typedef struct { int x; int y; int fuse; int owner; } bomb_t;
  bomb_t         bq[$];
  int            m_health [NP];
  bit            m_over, m_draw;
  int            m_winner;
  logic [NC-1:0] m_blast;
  logic [NP-1:0] exp_rdy, got_rdy;
  int            nchecks = 0, nerrors = 0;

  function automatic int pcx(int p); return int'(place_x[p*CWB +: CWB]); endfunction
  function automatic int pcy(int p); return int'(place_y[p*CWB +: CWB]); endfunction
  function automatic int plx(int p); return int'(player_x[p*CWB +: CWB]); endfunction
  function automatic int ply(int p); return int'(player_y[p*CWB +: CWB]); endfunction

  function automatic void model_reset();
    bq.delete();
    for (int p = 0; p < NP; p++) m_health[p] = MH;
    m_over = 0; m_draw = 0; m_winner = 0; m_blast = '0;
  endfunction

  function automatic bit occupied(int x, int y);
    foreach (bq[i]) if (bq[i].x == x && bq[i].y == y) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NP-1:0] model_rdy();
    logic [NP-1:0] r;
    int x, y, n;
    bit clash;
    r = '0;
    for (int p = 0; p < NP; p++) begin
      x = pcx(p); y = pcy(p); n = 0; clash = 0;
      foreach (bq[i]) if (bq[i].owner == p) n++;
      for (int q = 0; q < p; q++) if (place_v[q] && pcx(q) == x && pcy(q) == y) clash = 1;
      r[p] = place_v[p] && x < GW && y < GH && !occupied(x, y) && m_health[p] > 0 &&
             n < MB && !m_over && !clash;
    end
    return r;
  endfunction

  function automatic void model_edge(bit t, logic [NP-1:0] r);
    bomb_t keep[$];
    bomb_t e;
    logic [NC-1:0] b;
    int n_alive, last, x, y;
    if (t) begin
      b = '0;
      for (int cy = 0; cy < GH; cy++)
        for (int cx = 0; cx < GW; cx++)
          foreach (bq[i])
            if (bq[i].fuse == 1 &&
                ((cy == bq[i].y && cx - bq[i].x <= R && bq[i].x - cx <= R) ||
                 (cx == bq[i].x && cy - bq[i].y <= R && bq[i].y - cy <= R)))
              b[cy*GW + cx] = 1'b1;
      foreach (bq[i]) begin
        if (bq[i].fuse != 1) begin
          e = bq[i];
          e.fuse = b[e.y*GW + e.x] ? 1 : e.fuse - 1;
          keep.push_back(e);
        end
      end
      bq = keep;
      m_blast = b;
      if (!m_over) begin
        n_alive = 0; last = 0;
        for (int p = 0; p < NP; p++) begin
          x = plx(p); y = ply(p);
          if (x < GW && y < GH && b[y*GW + x] && m_health[p] > 0) m_health[p]--;
          if (m_health[p] > 0) begin n_alive++; last = p; end
        end
        if (n_alive == 1) begin m_over = 1; m_winner = last; end
        else if (n_alive == 0) begin m_over = 1; m_draw = 1; end
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (r[p]) begin
        e.x = pcx(p); e.y = pcy(p); e.fuse = FUSE; e.owner = p;
        bq.push_back(e);
      end
    end
  endfunction

  function automatic logic [NC-1:0] exp_bomb_map();
    logic [NC-1:0] m;
    m = '0;
    foreach (bq[i]) m[bq[i].y*GW + bq[i].x] = 1'b1;
    return m;
  endfunction

  function automatic logic [NP*HWB-1:0] exp_health();
    logic [NP*HWB-1:0] h;
    for (int p = 0; p < NP; p++) h[p*HWB +: HWB] = HWB'(m_health[p]);
    return h;
  endfunction

  task automatic step(input bit t);
    tick_en = t;
    @(negedge bombClk);
    exp_rdy = model_rdy();
    got_rdy = place_rdy;
    @(posedge bombClk);
    model_edge(t, exp_rdy);
    #1;
    tick_en = 1'b0;
    place_v = '0;
  endtask

  task automatic do_reset();
    place_v = '0; tick_en = 1'b0;
    @(negedge bombClk);
    rst = 1'b1; #2; rst = 1'b0;
    model_reset();
    @(posedge bombClk); #1;
  endtask

  task automatic set_place(input int p, input int x, input int y);
    place_v[p] = 1'b1;
    place_x[p*CWB +: CWB] = CWB'(x);
    place_y[p*CWB +: CWB] = CWB'(y);
  endtask

  task automatic set_pos(input int p, input int x, input int y);
    player_x[p*CWB +: CWB] = CWB'(x);
    player_y[p*CWB +: CWB] = CWB'(y);
  endtask

  task automatic test_reset();
    do_reset();
    nchecks++; if (bomb_map !== '0) begin nerrors++; $display("FAIL reset_bomb_map got=%h exp=0", bomb_map); end
    nchecks++; if (blast_map !== '0) begin nerrors++; $display("FAIL reset_blast_map got=%h exp=0", blast_map); end
    nchecks++; if (health !== 4'b1111) begin nerrors++; $display("FAIL reset_health got=%b exp=1111", health); end
    nchecks++; if ({alive, game_over, winner, draw} !== 6'b110000) begin
      nerrors++; $display("FAIL reset_status got=%b exp=110000", {alive, game_over, winner, draw});
    end
  endtask

  task automatic test_single_bomb();
    logic [NC-1:0] exp_b;
    do_reset(); set_pos(0, 9, 9); set_pos(1, 9, 0);
    set_place(0, 3, 3); step(0);
    nchecks++; if (got_rdy !== 2'b01) begin nerrors++; $display("FAIL single_rdy got=%b exp=01", got_rdy); end
    step(1);
    nchecks++; if (bomb_map[33] !== 1'b1) begin nerrors++; $display("FAIL single_live1 got=%b exp=1", bomb_map[33]); end
    step(1);
    nchecks++; if (bomb_map[33] !== 1'b1) begin nerrors++; $display("FAIL single_live2 got=%b exp=1", bomb_map[33]); end
    step(1);
    exp_b = '0;
    for (int i = 1; i <= 5; i++) begin exp_b[30 + i] = 1'b1; exp_b[i*10 + 3] = 1'b1; end
    nchecks++; if (bomb_map[33] !== 1'b0) begin nerrors++; $display("FAIL single_gone got=%b exp=0", bomb_map[33]); end
    nchecks++; if (blast_map !== exp_b) begin nerrors++; $display("FAIL single_blast got=%h exp=%h", blast_map, exp_b); end
    set_place(0, 3, 3); step(0);
    nchecks++; if (blast_map !== exp_b) begin nerrors++; $display("FAIL single_blast_hold got=%h exp=%h", blast_map, exp_b); end
    nchecks++; if (got_rdy !== 2'b01) begin nerrors++; $display("FAIL single_count_freed got=%b exp=01", got_rdy); end
    step(1);
    nchecks++; if (blast_map !== '0) begin nerrors++; $display("FAIL single_blast_clear got=%h exp=0", blast_map); end
  endtask

  task automatic test_damage();
    do_reset(); set_pos(0, 9, 9); set_pos(1, 3, 5);
    set_place(0, 3, 3); step(0);
    repeat (3) step(1);
    nchecks++; if (health !== 4'b1011) begin nerrors++; $display("FAIL damage_one got=%b exp=1011", health); end
    set_place(0, 3, 4); set_place(1, 4, 5); step(0);
    nchecks++; if (got_rdy !== 2'b11) begin nerrors++; $display("FAIL damage_rdy got=%b exp=11", got_rdy); end
    repeat (3) step(1);
    nchecks++; if (health !== 4'b0111) begin nerrors++; $display("FAIL damage_overlap got=%b exp=0111", health); end
    nchecks++; if (alive !== 2'b11) begin nerrors++; $display("FAIL damage_alive got=%b exp=11", alive); end
  endtask

  task automatic test_chain();
    do_reset(); set_pos(0, 9, 9); set_pos(1, 9, 0);
    set_place(0, 2, 2); step(0); step(1);
    set_place(1, 2, 4); step(0); step(1);
    step(1);
    nchecks++; if ({bomb_map[42], bomb_map[22]} !== 2'b10) begin
      nerrors++; $display("FAIL chain_first got=%b exp=10", {bomb_map[42], bomb_map[22]});
    end
    step(1);
    nchecks++; if (bomb_map[42] !== 1'b0) begin nerrors++; $display("FAIL chain_early got=%b exp=0", bomb_map[42]); end
    nchecks++; if ({blast_map[62], blast_map[42], blast_map[22], blast_map[2]} !== 4'b1110) begin
      nerrors++; $display("FAIL chain_blast got=%b exp=1110", {blast_map[62], blast_map[42], blast_map[22], blast_map[2]});
    end
  endtask

  task automatic test_arbitration();
    logic [NC-1:0] exp_b;
    do_reset(); set_pos(0, 9, 9); set_pos(1, 9, 0);
    set_place(0, 5, 5); set_place(1, 5, 5); step(0);
    nchecks++; if (got_rdy !== 2'b01) begin nerrors++; $display("FAIL arb_same_cell got=%b exp=01", got_rdy); end
    set_place(0, 6, 6); set_place(1, 5, 5); step(0);
    nchecks++; if (got_rdy !== 2'b00) begin nerrors++; $display("FAIL arb_max_occupied got=%b exp=00", got_rdy); end
    set_place(1, 10, 2); step(0);
    nchecks++; if (got_rdy !== 2'b00) begin nerrors++; $display("FAIL arb_out_of_range got=%b exp=00", got_rdy); end
    repeat (3) step(1);
    set_place(1, 0, 0); step(0);
    repeat (3) step(1);
    exp_b = '0;
    exp_b[0] = 1'b1; exp_b[1] = 1'b1; exp_b[2] = 1'b1; exp_b[10] = 1'b1; exp_b[20] = 1'b1;
    nchecks++; if (blast_map !== exp_b) begin nerrors++; $display("FAIL arb_clipped got=%h exp=%h", blast_map, exp_b); end
  endtask

  task automatic test_game_end();
    do_reset(); set_pos(0, 3, 6); set_pos(1, 3, 5);
    repeat (2) begin
      set_place(0, 3, 3); step(0);
      repeat (3) step(1);
    end
    set_place(0, 3, 3); step(0); step(1);
    set_place(1, 3, 4); step(0); step(1);
    step(1);
    nchecks++; if ({game_over, winner, draw} !== 4'b1000) begin
      nerrors++; $display("FAIL end_win got=%b exp=1000", {game_over, winner, draw});
    end
    nchecks++; if (health !== 4'b0011) begin nerrors++; $display("FAIL end_win_health got=%b exp=0011", health); end
    set_place(0, 7, 7); set_place(1, 8, 8); step(1);
    nchecks++; if (got_rdy !== 2'b00) begin nerrors++; $display("FAIL end_refuse got=%b exp=00", got_rdy); end
    nchecks++; if (health !== 4'b0011) begin nerrors++; $display("FAIL end_frozen got=%b exp=0011", health); end
    nchecks++; if (blast_map[63] !== 1'b1) begin nerrors++; $display("FAIL end_blast_drawn got=%b exp=1", blast_map[63]); end
    do_reset(); set_pos(0, 3, 5); set_pos(1, 3, 5);
    repeat (2) begin
      set_place(0, 3, 3); step(0);
      repeat (3) step(1);
    end
    nchecks++; if (health !== 4'b0101) begin nerrors++; $display("FAIL draw_pre got=%b exp=0101", health); end
    set_place(0, 3, 3); step(0);
    repeat (3) step(1);
    nchecks++; if ({game_over, draw, alive} !== 4'b1100) begin
      nerrors++; $display("FAIL draw_end got=%b exp=1100", {game_over, draw, alive});
    end
  endtask

  task automatic test_async_reset();
    do_reset(); set_pos(0, 9, 9); set_pos(1, 3, 5);
    set_place(0, 3, 3); step(0);
    repeat (3) step(1);
    set_place(0, 3, 3); step(0); step(1);
    @(negedge bombClk); #2;
    rst = 1'b1; #1;
    nchecks++; if ({bomb_map, blast_map} !== '0) begin nerrors++; $display("FAIL areset_maps got=%h exp=0", {bomb_map, blast_map}); end
    nchecks++; if ({health, alive, game_over, winner, draw} !== 10'b1111110000) begin
      nerrors++; $display("FAIL areset_status got=%b exp=1111110000", {health, alive, game_over, winner, draw});
    end
    rst = 1'b0;
    model_reset();
    @(posedge bombClk); #1;
    set_place(0, 4, 4); step(0);
    nchecks++; if (got_rdy !== 2'b01) begin nerrors++; $display("FAIL areset_count got=%b exp=01", got_rdy); end
  endtask

  task automatic test_random();
    do_reset(); set_pos(0, 1, 1); set_pos(1, 8, 8);
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        place_v[p] = ($urandom_range(0, 2) == 0);
        place_x[p*CWB +: CWB] = CWB'($urandom_range(0, 10));
        place_y[p*CWB +: CWB] = CWB'($urandom_range(0, 10));
        if ($urandom_range(0, 3) == 0) set_pos(p, $urandom_range(0, 11), $urandom_range(0, 11));
      end
      step($urandom_range(0, 2) == 0);
      nchecks++; if (got_rdy !== exp_rdy) begin nerrors++; $display("FAIL rnd_rdy n=%0d got=%b exp=%b", n, got_rdy, exp_rdy); end
      nchecks++; if (bomb_map !== exp_bomb_map()) begin nerrors++; $display("FAIL rnd_bomb_map n=%0d got=%h exp=%h", n, bomb_map, exp_bomb_map()); end
      nchecks++; if (blast_map !== m_blast) begin nerrors++; $display("FAIL rnd_blast_map n=%0d got=%h exp=%h", n, blast_map, m_blast); end
      nchecks++; if (health !== exp_health()) begin nerrors++; $display("FAIL rnd_health n=%0d got=%b exp=%b", n, health, exp_health()); end
      nchecks++; if (game_over !== m_over || draw !== m_draw) begin
        nerrors++; $display("FAIL rnd_end n=%0d got=%b%b exp=%b%b", n, game_over, draw, m_over, m_draw);
      end
      nchecks++; if (winner !== 2'(m_winner)) begin nerrors++; $display("FAIL rnd_winner n=%0d got=%0d exp=%0d", n, winner, m_winner); end
      if (m_over && $urandom_range(0, 5) == 0) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_single_bomb();
    test_damage();
    test_chain();
    test_arbitration();
    test_game_end();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
